// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencing controller:
// request opcodes, controller states and the default watchdog limit.
package muldiv_ctrl_pkg;

    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_EXC    = 3'd4
    } state_t;

    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multiply/divide units; owns HI/LO and stalls the
// control unit through Busy. Optional WAIT watchdog: define MULDIV_TIMEOUT_EN.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        OpValid,
    input  logic [1:0]  OpCode,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    output logic        MultStart,
    output logic        DivStart,
    output logic [31:0] UnitA,
    output logic [31:0] UnitB,
    input  logic        MultStop,
    input  logic        DivStop,
    input  logic [31:0] MultHI,
    input  logic [31:0] MultLO,
    input  logic [31:0] DivHI,
    input  logic [31:0] DivLO,
    input  logic        DivZero,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done,
    output logic        DivZeroExc,
    output logic        Timeout
);

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
            $error("muldiv_ctrl: TIMEOUT_CYCLES must be in 1..256");
        end
    endgenerate

    state_t state_r;
    logic   sel_div_r;

`ifdef MULDIV_TIMEOUT_EN
    logic [7:0] wd_cnt_r;
`else
    assign Timeout = 1'b0;
`endif

    // Controller FSM with registered pulses, operand latches and HI/LO.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            sel_div_r  <= 1'b0;
            UnitA      <= 32'd0;
            UnitB      <= 32'd0;
            HI         <= 32'd0;
            LO         <= 32'd0;
            MultStart  <= 1'b0;
            DivStart   <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            DivZeroExc <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            wd_cnt_r   <= 8'd0;
            Timeout    <= 1'b0;
`endif
        end else begin
            MultStart  <= 1'b0;
            DivStart   <= 1'b0;
            Done       <= 1'b0;
            DivZeroExc <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            Timeout    <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (OpValid) begin
                        case (OpCode)
                            OP_MTHI: HI <= OpA;
                            OP_MTLO: LO <= OpA;
                            OP_MULT, OP_DIV: begin
                                // A zero divisor never reaches the unit.
                                if (OpCode == OP_DIV && OpB == 32'd0) begin
                                    state_r    <= ST_EXC;
                                    Busy       <= 1'b1;
                                    DivZeroExc <= 1'b1;
                                end else begin
                                    UnitA     <= OpA;
                                    UnitB     <= OpB;
                                    sel_div_r <= (OpCode == OP_DIV);
                                    MultStart <= (OpCode == OP_MULT);
                                    DivStart  <= (OpCode == OP_DIV);
                                    Busy      <= 1'b1;
                                    state_r   <= ST_LAUNCH;
                                end
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_LAUNCH: begin
                    state_r <= ST_WAIT;
`ifdef MULDIV_TIMEOUT_EN
                    wd_cnt_r <= 8'd0;
`endif
                end
                ST_WAIT: begin
                    if (sel_div_r && DivZero) begin
                        state_r    <= ST_EXC;
                        DivZeroExc <= 1'b1;
                    end else if (sel_div_r ? DivStop : MultStop) begin
                        HI      <= sel_div_r ? DivHI : MultHI;
                        LO      <= sel_div_r ? DivLO : MultLO;
                        Done    <= 1'b1;
                        state_r <= ST_COMMIT;
                    end
`ifdef MULDIV_TIMEOUT_EN
                    else if (wd_cnt_r == 8'(TIMEOUT_CYCLES - 1)) begin
                        Timeout <= 1'b1;
                        Busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 8'd1;
                    end
`else
                    else begin
                        state_r <= ST_WAIT;
                    end
`endif
                end
                ST_COMMIT, ST_EXC: begin
                    Busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the CPU's iterative multiply and divide units, owning the architectural HI/LO registers. It accepts one MULT/DIV/MTHI/MTLO request at a time from the main control unit. It launches the selected unit with a one-cycle start pulse and waits for that unit's stop flag. It then commits the result to HI/LO, or raises a divide-by-zero exception, and stalls the control unit through `Busy` for the whole operation.

## Interface
- `TIMEOUT_CYCLES`, 64: WAIT-state watchdog limit in cycles; only used when `MULDIV_TIMEOUT_EN` is defined.
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `OpValid`  in  1  request strobe; sampled only in IDLE.
- `OpCode`  in  2  0 MULT, 1 DIV, 2 MTHI, 3 MTLO.
- `OpA`, `OpB`  in  32 each  operands. MTHI/MTLO use `OpA`.
- `MultStart`, `DivStart`  out  1 each  one-cycle launch pulses.
- `UnitA`, `UnitB`  out  32 each  registered operands to both units; stable from LAUNCH through WAIT.
- `MultStop`, `DivStop`  in  1 each  unit completion flags.
- `MultHI`, `MultLO`, `DivHI`, `DivLO`  in  32 each  unit results; valid while the matching stop flag is high.
- `DivZero`  in  1  divide-by-zero flag from the divide unit.
- `HI`, `LO`  out  32 each  architectural registers.
- `Busy`  out  1  high whenever state is not IDLE.
- `Done`  out  1  one-cycle pulse on a successful MULT/DIV commit.
- `DivZeroExc`  out  1  one-cycle exception pulse.
- `Timeout`  out  1  one-cycle watchdog pulse.

## Operation
- States: IDLE, LAUNCH, WAIT, COMMIT, EXC.
- IDLE, `OpValid=1`:
  - MTHI/MTLO: write `OpA` into HI or LO at that edge. State stays IDLE, `Busy` stays low, `Done` is not pulsed.
  - MULT: latch `OpA`/`OpB` into `UnitA`/`UnitB`, record the selected unit, go to LAUNCH.
  - DIV with `OpB!=0`: same as MULT.
  - DIV with `OpB==0`: go to EXC. No `DivStart` is issued.
- LAUNCH: assert the selected unit's start pulse for exactly one cycle, then go to WAIT. Stop flags are ignored in this state.
- WAIT: sample only the selected unit's stop flag; the other unit's stop flag is ignored.
  - Stop high and `DivZero` low: capture that unit's HI/LO into the HI/LO registers, go to COMMIT.
  - DIV with `DivZero` high (takes priority over stop): go to EXC, HI/LO unchanged.
- COMMIT: `Done=1` for one cycle, then go to IDLE.
- EXC: `DivZeroExc=1` for one cycle, then go to IDLE.
- `OpValid` is ignored in every state except IDLE. No queuing; the control unit holds the request until `Busy` is low.
- No arithmetic in this block. Results are copied bit-exact at full 32-bit width.

## Timing
- Reset (asynchronous, any state, including mid-WAIT):
  - state returns to IDLE;
  - HI, LO, UnitA, UnitB clear to 0;
  - all pulse outputs and `Busy` go to 0;
  - the watchdog counter clears;
  - a unit result arriving after reset is ignored.
- Accept edge is cycle 0. `Busy` rises in cycle 1 and the start pulse is in cycle 1. Stop sampling begins in cycle 2.
- If stop is sampled at edge N, HI/LO update at edge N and `Done` is high during cycle N+1. `Busy` drops in cycle N+2.
- Zero-divisor path: `DivZeroExc` is high in cycle 1 and `Busy` drops in cycle 2.
- Minimum MULT/DIV occupancy is 3 cycles, for a unit that stops immediately.

## Configuration
- `MULDIV_TIMEOUT_EN` defined:
  - an 8-bit counter runs in WAIT;
  - on reaching `TIMEOUT_CYCLES` without a stop, go to IDLE, pulse `Timeout` for one cycle, leave HI/LO unchanged;
  - a stop arriving on the same edge as expiry wins and commits normally.
- Undefined: no counter is built, `Timeout` is tied to 0, and WAIT persists until stop.

## Structure
- Shared package holds:
  - the `OpCode` encodings as constants (OP_MULT, OP_DIV, OP_MTHI, OP_MTLO);
  - the state encoding;
  - the default timeout value.
- Single flat module. The optional watchdog counter is small enough to stay inline; no sub-module.

## Test plan
- MULT 7×6, stub unit stops after 33 cycles: expect `MultStart` in cycle 1 only, then LO=42, HI=0, one `Done` pulse, `Busy` low afterward.
- DIV 100/7: expect LO=14, HI=2, `Done` pulse, and `MultStart` never asserted.
- DIV with `OpB=0`, HI=5 and LO=9 preloaded: expect `DivZeroExc` in cycle 1, no `DivStart`, HI/LO still 5/9.
- MTHI 0xDEADBEEF issued while a DIV is in WAIT: expect it to be ignored. Reissue after `Busy` drops: expect HI=0xDEADBEEF with no `Busy`.
- Reset asserted mid-WAIT of a DIV, then stop asserted later: expect state IDLE, HI=LO=0, no `Done`.
- With `MULDIV_TIMEOUT_EN`, stub never stops: expect `Timeout` after 64 WAIT cycles, HI/LO unchanged, `Busy` low afterward.
